ss_signed_decoder: RTL and testbench
====================================

SS_SIGNED_DECODER -- requirements
Module: ss_signed_decoder

Interface
REQ-001 SHALL have parameter WINDOW_BITS, default 4: window length is 2^WINDOW_BITS enabled cycles.
REQ-002 SHALL have parameter OUT_WIDTH, default WINDOW_BITS+2: signed result width; values below WINDOW_BITS+2 are illegal.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port INIT, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port EN, input, 1 bit: stream-sample qualifier; cycles with EN=0 are ignored.
REQ-006 SHALL have port IN, input, 1 bit: stochastic magnitude bit from the upstream add/sub stage.
REQ-007 SHALL have port SIGN_in, input, 1 bit: sign of IN, where 1 means negative.
REQ-008 SHALL have port START, input, 1 bit: begins accumulation when the block is in IDLE.
REQ-009 SHALL have port CONT, input, 1 bit: 1 selects back-to-back windows, 0 selects a single window.
REQ-010 SHALL have port RDY, input, 1 bit: consumer accepts VALUE.
REQ-011 SHALL have port VALUE, output, OUT_WIDTH bits: two's-complement window result.
REQ-012 SHALL have port VALID, output, 1 bit: VALUE holds an unconsumed result.
REQ-013 SHALL have port BUSY, output, 1 bit: high while in ACCUM.
REQ-014 SHALL have port OVR, output, 1 bit: sticky overrun flag; present only when the macro in REQ-028 is defined.

Function
REQ-015 SHALL implement two states, IDLE and ACCUM; IDLE->ACCUM when START=1; ACCUM->IDLE at window end if CONT=0, otherwise SHALL stay in ACCUM.
REQ-016 SHALL ignore START while in ACCUM.
REQ-017 In ACCUM with EN=1, SHALL update the accumulator: +1 if IN=1 and SIGN_in=0; -1 if IN=1 and SIGN_in=1; unchanged if IN=0.
REQ-018 In ACCUM with EN=1, SHALL increment the WINDOW_BITS-bit sample counter; with EN=0, accumulator and counter SHALL hold.
REQ-019 On the enabled cycle where the counter equals 2^WINDOW_BITS-1, SHALL load VALUE with the accumulator including that cycle's contribution, clear the accumulator, and wrap the counter to 0; this is window end.
REQ-020 SHALL assert VALID on the cycle after window end; latency from the last sample to VALID is 1 cycle.
REQ-021 SHALL clear VALID on the cycle after VALID=1 and RDY=1, unless window end occurs in the same cycle, in which case VALID SHALL remain 1 carrying the new VALUE.
REQ-022 SHALL hold VALUE stable while VALID=1 and no window end occurs.
REQ-023 SHALL keep the result range within -2^WINDOW_BITS..+2^WINDOW_BITS, with no saturation needed, sign-extended to OUT_WIDTH.
REQ-024 Window end with VALID=1 and RDY=0 SHALL overwrite VALUE with the new result (overrun).
REQ-025 SHALL sample IN and EN while in IDLE as don't-care; the accumulator stays 0.

Reset
REQ-026 INIT=1 SHALL, on the next clock edge, force IDLE, counter=0, accumulator=0, VALUE=0, VALID=0, BUSY=0, OVR=0, overriding all other inputs including START.
REQ-027 INIT asserted mid-window SHALL discard the partial window; the first window after release starts at counter 0.

Configuration
REQ-028 Macro SS_DECODE_OVR_EN defined: SHALL build the OVR port; OVR is set on the overrun of REQ-024 and cleared only by INIT.
REQ-029 Macro SS_DECODE_OVR_EN undefined: SHALL omit the OVR port and its register; overrun still overwrites VALUE silently.

Structure
REQ-030 A shared package ss_pkg SHALL hold the state encoding (IDLE=0, ACCUM=1) and a width constant/function for the default OUT_WIDTH.
REQ-031 SHALL instantiate one sub-module, ss_updown_acc (signed up/down accumulator with hold and clear), containing the data path; control and handshake SHALL stay in ss_signed_decoder.

Verification (WINDOW_BITS=4)
REQ-032 START, CONT=0, IN=1, SIGN_in=0, EN=1 for 16 cycles -> VALUE=+16, VALID 1 cycle after the 16th sample, state returns to IDLE.
REQ-033 Same as REQ-032 with SIGN_in=1 -> VALUE=-16 (0x30 at 6 bits); then RDY=1 -> VALID=0 on the next cycle.
REQ-034 CONT=1, alternating (IN=1,SIGN_in=0)/(IN=1,SIGN_in=1), EN low every third cycle -> each window yields VALUE=0, windows span 24 clocks.
REQ-035 CONT=1, RDY=0 for two windows, first yields +5 and second +3 -> VALUE=3, VALID=1, OVR=1 with the macro, and no OVR port without it.
REQ-036 INIT pulsed after 9 samples, then START with 16 IN=1, SIGN_in=0 samples -> VALUE=+16, proving the partial window was discarded; all outputs 0 the cycle after INIT.
REQ-037 Window end in the same cycle as RDY=1 with VALID=1 -> VALID stays 1 and VALUE updates to the new result.

Source files
------------

// File: rtl/ss_pkg.sv
// ss_pkg: shared state encoding and width helpers for the signed stochastic decoder
package ss_pkg;
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
    localparam int DEFAULT_WINDOW_BITS = 4;
    function automatic int out_width(input int window_bits);
        return window_bits + 2;
    endfunction
endpackage

// File: rtl/ss_updown_acc.sv
// ss_updown_acc: signed up/down accumulator with hold and synchronous clear
module ss_updown_acc #(
    parameter int WIDTH = 6
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic in,
    input  logic neg,
    output logic signed [WIDTH-1:0] sum
);
    logic signed [WIDTH-1:0] acc;
    // running total including this cycle's contribution, so a window end can capture it directly
    always_comb sum = in ? (neg ? acc - WIDTH'(1) : acc + WIDTH'(1)) : acc;
    // clear wins over everything; otherwise advance only on enabled cycles
    always_ff @(posedge clk) begin
        if (clr) acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/ss_signed_decoder.sv
// ss_signed_decoder: windowed signed stochastic-stream decoder with ready/valid result; SS_DECODE_OVR_EN adds a sticky OVR flag
module ss_signed_decoder
    import ss_pkg::*;
#(
    parameter int WINDOW_BITS = DEFAULT_WINDOW_BITS,
    parameter int OUT_WIDTH = out_width(WINDOW_BITS)
) (
    input  logic CLK,
    input  logic INIT,
    input  logic EN,
    input  logic IN,
    input  logic SIGN_in,
    input  logic START,
    input  logic CONT,
    input  logic RDY,
    output logic [OUT_WIDTH-1:0] VALUE,
    output logic VALID,
    output logic BUSY
`ifdef SS_DECODE_OVR_EN
    ,
    output logic OVR
`endif
);
    localparam int AW = WINDOW_BITS + 2;
    state_t state;
    logic [WINDOW_BITS-1:0] cnt;
    logic signed [AW-1:0] sum;
    logic step, wend;
    assign step = (state == ACCUM) && EN;
    assign wend = step && (cnt == '1);
    assign BUSY = (state == ACCUM);
    ss_updown_acc #(.WIDTH(AW)) u_acc (
        .clk(CLK),
        .clr(INIT || wend || state == IDLE),
        .en (step),
        .in (IN),
        .neg(SIGN_in),
        .sum(sum)
    );
    // control FSM, sample counter and result handshake; a window end beats a same-cycle consume
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state <= IDLE;
            cnt   <= '0;
            VALUE <= '0;
            VALID <= 1'b0;
        end else begin
            if (state == IDLE && START) state <= ACCUM;
            else if (wend && !CONT) state <= IDLE;
            if (step) cnt <= cnt + WINDOW_BITS'(1);
            if (wend) VALUE <= OUT_WIDTH'(sum);
            if (wend) VALID <= 1'b1;
            else if (RDY) VALID <= 1'b0;
        end
    end
`ifdef SS_DECODE_OVR_EN
    // sticky: a result was replaced before the consumer took it
    always_ff @(posedge CLK) begin
        if (INIT) OVR <= 1'b0;
        else if (wend && VALID && !RDY) OVR <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_ss_signed_decoder.sv
// tb_ss_signed_decoder: directed table-driven bench for ss_signed_decoder (WINDOW_BITS=4)
module tb_ss_signed_decoder;
    logic CLK = 1'b0;
    logic INIT, EN, IN, SIGN_in, START, CONT, RDY;
    logic [5:0] VALUE;
    logic VALID, BUSY;
`ifdef SS_DECODE_OVR_EN
    logic OVR;
`endif
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    ss_signed_decoder dut (
        .CLK(CLK), .INIT(INIT), .EN(EN), .IN(IN), .SIGN_in(SIGN_in),
        .START(START), .CONT(CONT), .RDY(RDY),
        .VALUE(VALUE), .VALID(VALID), .BUSY(BUSY)
`ifdef SS_DECODE_OVR_EN
        , .OVR(OVR)
`endif
    );

    typedef struct {
        logic [15:0] in_bits;
        logic [15:0] neg_bits;
        int          exp;
    } vec_t;
    vec_t vecs[8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input logic i, input logic n);
        EN = 1'b1; IN = i; SIGN_in = n;
        step();
        EN = 1'b0; IN = 1'b0; SIGN_in = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_init();
        INIT = 1'b1; START = 1'b0; CONT = 1'b0; RDY = 1'b0;
        step();
        INIT = 1'b0;
    endtask

    task automatic check_ovr(input string name, input int exp);
`ifdef SS_DECODE_OVR_EN
        chk(name, int'(OVR), exp);
`endif
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0000,   0};
        vecs[1] = '{16'hFFFF, 16'h0000,  16};
        vecs[2] = '{16'hFFFF, 16'hFFFF, -16};
        vecs[3] = '{16'h00FF, 16'h0000,   8};
        vecs[4] = '{16'hFFFF, 16'h00FF,   0};
        vecs[5] = '{16'h001F, 16'h0003,   1};
        vecs[6] = '{16'h0F0F, 16'h0001,   6};
        vecs[7] = '{16'h0007, 16'h0007,  -3};

        EN = 0; IN = 0; SIGN_in = 0; START = 0; CONT = 0; RDY = 0; INIT = 0;
        // INIT must override a simultaneous START
        INIT = 1'b1; START = 1'b1;
        step();
        INIT = 1'b0; START = 1'b0;
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_valid", int'(VALID), 0);
        chk("reset_value", int'(VALUE), 0);
        check_ovr("reset_ovr", 0);

        // samples while IDLE must not accumulate
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b0);
        chk("idle_busy", int'(BUSY), 0);

        for (int v = 0; v < 8; v++) begin
            START = 1'b1;
            step();
            START = 1'b0;
            chk($sformatf("v%0d_busy", v), int'(BUSY), 1);
            for (int i = 0; i < 16; i++) begin
                sample(vecs[v].in_bits[i], vecs[v].neg_bits[i]);
                if (i == 14) chk($sformatf("v%0d_early_valid", v), int'(VALID), 0);
            end
            chk($sformatf("v%0d_valid", v), int'(VALID), 1);
            chk($sformatf("v%0d_value", v), int'($signed(VALUE)), vecs[v].exp);
            chk($sformatf("v%0d_idle", v), int'(BUSY), 0);
            step();
            chk($sformatf("v%0d_hold_value", v), int'($signed(VALUE)), vecs[v].exp);
            chk($sformatf("v%0d_hold_valid", v), int'(VALID), 1);
            RDY = 1'b1;
            step();
            RDY = 1'b0;
            chk($sformatf("v%0d_consumed", v), int'(VALID), 0);
        end

        // -16 encodes as 6'h30
        do_init();
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b1);
        chk("neg16_raw", int'(VALUE), 'h30);
        RDY = 1'b1; step(); RDY = 1'b0;
        chk("neg16_consumed", int'(VALID), 0);

        // back-to-back windows, alternating signs, EN low every third clock
        do_init();
        CONT = 1'b1;
        START = 1'b1; step(); START = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 1; c <= 48; c++) begin
                if (c % 3 == 1) step();
                else begin
                    sample(1'b1, k[0]);
                    k++;
                end
                if (c == 23) chk("alt_w1_early", int'(VALID), 0);
                if (c == 24) begin
                    chk("alt_w1_valid", int'(VALID), 1);
                    chk("alt_w1_value", int'($signed(VALUE)), 0);
                    chk("alt_w1_busy", int'(BUSY), 1);
                    RDY = 1'b1;
                end
                if (c == 25) begin
                    chk("alt_w1_consumed", int'(VALID), 0);
                    RDY = 1'b0;
                end
                if (c == 47) chk("alt_w2_early", int'(VALID), 0);
                if (c == 48) begin
                    chk("alt_w2_valid", int'(VALID), 1);
                    chk("alt_w2_value", int'($signed(VALUE)), 0);
                    chk("alt_w2_busy", int'(BUSY), 1);
                end
            end
        end

        // overrun: two windows without a consumer
        do_init();
        CONT = 1'b1;
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 16; i++) sample(i < 5, 1'b0);
        chk("ovr_w1_value", int'($signed(VALUE)), 5);
        chk("ovr_w1_valid", int'(VALID), 1);
        check_ovr("ovr_w1_flag", 0);
        for (int i = 0; i < 16; i++) sample(i < 3, 1'b0);
        chk("ovr_w2_value", int'($signed(VALUE)), 3);
        chk("ovr_w2_valid", int'(VALID), 1);
        chk("ovr_w2_busy", int'(BUSY), 1);
        check_ovr("ovr_w2_flag", 1);

        // INIT mid-window discards the partial sum
        do_init();
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 9; i++) sample(1'b1, 1'b0);
        do_init();
        chk("init_value", int'(VALUE), 0);
        chk("init_valid", int'(VALID), 0);
        chk("init_busy", int'(BUSY), 0);
        check_ovr("init_ovr", 0);
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b0);
        chk("init_after_value", int'($signed(VALUE)), 16);
        chk("init_after_valid", int'(VALID), 1);
        chk("init_after_busy", int'(BUSY), 0);

        // window end coinciding with consume keeps VALID and loads the new value; START ignored in ACCUM
        do_init();
        CONT = 1'b1;
        START = 1'b1; step(); START = 1'b0;
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b0);
        chk("same_w1_value", int'($signed(VALUE)), 16);
        START = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) RDY = 1'b1;
            sample(i < 2, 1'b1);
        end
        START = 1'b0;
        chk("same_w2_valid", int'(VALID), 1);
        chk("same_w2_value", int'($signed(VALUE)), -2);
        check_ovr("same_w2_ovr", 0);
        step();
        chk("same_w2_consumed", int'(VALID), 0);
        do_init();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
